// File: rtl/uvma_debug_req_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uvma_debug_req_chk_pkg
// Purpose  : Shared constants for the debug-request protocol checker:
//            hart FSM state encoding, error vector indices, pulse counter
//            width and its saturation helper.
// Revision : 1.0 - initial release
// ============================================================================
package uvma_debug_req_chk_pkg;

  // Hart FSM state encoding
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] hart_state_t;

  localparam hart_state_t ST_IDLE      = 2'd0;
  localparam hart_state_t ST_REQ       = 2'd1;
  localparam hart_state_t ST_WAIT_HALT = 2'd2;
  localparam hart_state_t ST_HALTED    = 2'd3;

  // Bit positions inside a hart's error vector
  localparam int unsigned ERR_SHORT    = 0;
  localparam int unsigned ERR_LONG     = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;
  localparam int unsigned ERR_SPURIOUS = 3;
  localparam int unsigned NUM_ERR      = 4;

  // Consecutive-high-cycle counter width
  localparam int unsigned PCNT_W = 16;

  // Saturation point of the pulse counter: MAX_PULSE+1 when bounded,
  // all-ones when the long-pulse check is disabled (max_pulse == 0).
  function automatic logic [PCNT_W-1:0] pcnt_sat(input int unsigned max_pulse);
    logic [PCNT_W-1:0] v;
    if (max_pulse == 0) v = '1;
    else                v = PCNT_W'(max_pulse + 1);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uvma_debug_req_chk_hart.sv
`default_nettype none
// ============================================================================
// Module   : uvma_debug_req_chk_hart
// Purpose  : One hart channel of the debug-request checker: edge detection,
//            request/halt FSM with ack timer, pulse-width counter, error
//            pulses and wrapping event counters. All outputs are registered
//            (one cycle after the sampled edge).
// Revision : 1.0 - initial release
// ============================================================================
module uvma_debug_req_chk_hart
  import uvma_debug_req_chk_pkg::*;
#(
  parameter int unsigned MIN_PULSE   = 1,
  parameter int unsigned MAX_PULSE   = 0,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               req_i,
  input  logic               halted_i,
  output logic [NUM_ERR-1:0] err_o,
  output logic [CNT_W-1:0]   req_cnt_o,
  output logic [CNT_W-1:0]   halt_cnt_o
);

  localparam int unsigned       TMR_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_SAT  = pcnt_sat(MAX_PULSE);
  localparam logic [PCNT_W-1:0] PCNT_MIN  = PCNT_W'(MIN_PULSE);
  localparam logic [PCNT_W-1:0] PCNT_LONG = PCNT_W'(MAX_PULSE);

  logic               req_q, halted_q;
  hart_state_t        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  // Set while the current high pulse started from IDLE and is width-checked
  logic               pchk_q, pchk_d;
  logic [NUM_ERR-1:0] err_q, err_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   halt_cnt_q, halt_cnt_d;

  logic w_req_rise, w_req_fall, w_halt_rise, w_halt_fall;

  assign w_req_rise  = req_i & ~req_q;
  assign w_req_fall  = ~req_i & req_q;
  assign w_halt_rise = halted_i & ~halted_q;
  assign w_halt_fall = ~halted_i & halted_q;

  // Next-state: FSM, ack timer, pulse counter, error pulses, event counters
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pcnt_d     = '0;
    pchk_d     = 1'b0;
    err_d      = '0;
    req_cnt_d  = req_cnt_q;
    halt_cnt_d = halt_cnt_q;

    if (!enable_i) begin
      // Disabled: everything parked, counters frozen, no errors
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      if (req_i) pcnt_d = (pcnt_q == PCNT_SAT) ? pcnt_q : pcnt_q + 1'b1;

      pchk_d = pchk_q;
      if (w_req_rise)      pchk_d = (state_q == ST_IDLE);
      else if (w_req_fall) pchk_d = 1'b0;

      err_d[ERR_SHORT] = pchk_q && w_req_fall && (pcnt_q < PCNT_MIN);
      // Fires on the cycle the count steps from MAX_PULSE to MAX_PULSE+1;
      // saturation at MAX_PULSE+1 keeps it to a single pulse.
      err_d[ERR_LONG]  = (MAX_PULSE != 0) && pchk_q && req_i && (pcnt_q == PCNT_LONG);

      if (w_req_rise)  req_cnt_d  = req_cnt_q + 1'b1;
      if (w_halt_rise) halt_cnt_d = halt_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (w_halt_rise) begin
            // A simultaneous request legitimises the halt
            state_d             = ST_HALTED;
            err_d[ERR_SPURIOUS] = ~w_req_rise;
          end else if (w_req_rise) begin
            state_d = ST_REQ;
            timer_d = TMR_ONE;
          end
        end
        ST_REQ, ST_WAIT_HALT: begin
          // Halt has priority over an expiring timer
          if (w_halt_rise) begin
            state_d = ST_HALTED;
            timer_d = '0;
          end else if (timer_q == TMR_MAX) begin
            state_d            = ST_IDLE;
            timer_d            = '0;
            err_d[ERR_TIMEOUT] = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
            if ((state_q == ST_REQ) && w_req_fall) state_d = ST_WAIT_HALT;
          end
        end
        ST_HALTED: begin
          if (w_halt_fall) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // State registers; edge-detect samples track inputs even while disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q      <= 1'b0;
      halted_q   <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pcnt_q     <= '0;
      pchk_q     <= 1'b0;
      err_q      <= '0;
      req_cnt_q  <= '0;
      halt_cnt_q <= '0;
    end else begin
      req_q      <= req_i;
      halted_q   <= halted_i;
      state_q    <= state_d;
      timer_q    <= timer_d;
      pcnt_q     <= pcnt_d;
      pchk_q     <= pchk_d;
      err_q      <= err_d;
      req_cnt_q  <= req_cnt_d;
      halt_cnt_q <= halt_cnt_d;
    end
  end

  assign err_o      = err_q;
  assign req_cnt_o  = req_cnt_q;
  assign halt_cnt_o = halt_cnt_q;

`ifdef UVMA_DEBUG_REQ_CHK_SVA_EN
  // Halt-latency observation points for coverage in the top
  logic w_cov_lat_one, w_cov_lat_max;
  assign w_cov_lat_one = enable_i && w_halt_rise &&
                         ((state_q == ST_REQ) || (state_q == ST_WAIT_HALT)) &&
                         (timer_q == TMR_ONE);
  assign w_cov_lat_max = enable_i && w_halt_rise &&
                         ((state_q == ST_REQ) || (state_q == ST_WAIT_HALT)) &&
                         (timer_q == TMR_MAX);
`endif

endmodule
`default_nettype wire

// File: rtl/uvma_debug_req_chk.sv
`default_nettype none
// ============================================================================
// Module   : uvma_debug_req_chk
// Purpose  : Passive multi-hart debug-request protocol checker. One
//            independent channel per hart; this level only slices ports.
//            Define UVMA_DEBUG_REQ_CHK_SVA_EN to compile the concurrent
//            assertions on every error bit and the FSM/latency covers.
// Revision : 1.0 - initial release
// ============================================================================
module uvma_debug_req_chk
  import uvma_debug_req_chk_pkg::*;
#(
  parameter int unsigned NUM_HARTS   = 1,
  parameter int unsigned MIN_PULSE   = 1,
  parameter int unsigned MAX_PULSE   = 0,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_HARTS-1:0]       debug_req,
  input  logic [NUM_HARTS-1:0]       debug_halted,
  output logic [NUM_HARTS-1:0]       err_pulse_short,
  output logic [NUM_HARTS-1:0]       err_pulse_long,
  output logic [NUM_HARTS-1:0]       err_ack_timeout,
  output logic [NUM_HARTS-1:0]       err_spurious,
  output logic [NUM_HARTS*CNT_W-1:0] req_cnt,
  output logic [NUM_HARTS*CNT_W-1:0] halt_cnt
);

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic [NUM_ERR-1:0] w_err;

    uvma_debug_req_chk_hart #(
      .MIN_PULSE   (MIN_PULSE),
      .MAX_PULSE   (MAX_PULSE),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_W       (CNT_W)
    ) u_hart (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .enable_i   (enable),
      .req_i      (debug_req[h]),
      .halted_i   (debug_halted[h]),
      .err_o      (w_err),
      .req_cnt_o  (req_cnt[h*CNT_W +: CNT_W]),
      .halt_cnt_o (halt_cnt[h*CNT_W +: CNT_W])
    );

    assign err_pulse_short[h] = w_err[ERR_SHORT];
    assign err_pulse_long[h]  = w_err[ERR_LONG];
    assign err_ack_timeout[h] = w_err[ERR_TIMEOUT];
    assign err_spurious[h]    = w_err[ERR_SPURIOUS];

`ifdef UVMA_DEBUG_REQ_CHK_SVA_EN
    a_short: assert property (@(posedge clk) disable iff (!reset_n) !err_pulse_short[h])
      else $error("uvma_debug_req_chk: hart %0d debug_req pulse shorter than MIN_PULSE", h);
    a_long: assert property (@(posedge clk) disable iff (!reset_n) !err_pulse_long[h])
      else $error("uvma_debug_req_chk: hart %0d debug_req pulse longer than MAX_PULSE", h);
    a_timeout: assert property (@(posedge clk) disable iff (!reset_n) !err_ack_timeout[h])
      else $error("uvma_debug_req_chk: hart %0d no halt within ACK_TIMEOUT", h);
    a_spurious: assert property (@(posedge clk) disable iff (!reset_n) !err_spurious[h])
      else $error("uvma_debug_req_chk: hart %0d halted without request", h);

    c_idle_req: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_IDLE) ##1 (u_hart.state_q == ST_REQ));
    c_idle_halted: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_IDLE) ##1 (u_hart.state_q == ST_HALTED));
    c_req_wait: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_REQ) ##1 (u_hart.state_q == ST_WAIT_HALT));
    c_req_halted: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_REQ) ##1 (u_hart.state_q == ST_HALTED));
    c_req_idle: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_REQ) ##1 (u_hart.state_q == ST_IDLE));
    c_wait_halted: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_WAIT_HALT) ##1 (u_hart.state_q == ST_HALTED));
    c_wait_idle: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_WAIT_HALT) ##1 (u_hart.state_q == ST_IDLE));
    c_halted_idle: cover property (@(posedge clk) disable iff (!reset_n)
      (u_hart.state_q == ST_HALTED) ##1 (u_hart.state_q == ST_IDLE));
    c_lat_one: cover property (@(posedge clk) disable iff (!reset_n) u_hart.w_cov_lat_one);
    c_lat_max: cover property (@(posedge clk) disable iff (!reset_n) u_hart.w_cov_lat_max);
`endif
  end

endmodule
`default_nettype wire
